// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order register-file writeback queue with one retire per cycle.
// Define WBQ_BYPASS_EN to build the A1/A2 bypass lookup; otherwise hit/byp are tied to zero.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_addr,
    input  logic [31:0]   in_data,
    input  logic          wb_hold,
    output logic          RegWrite,
    output logic [4:0]    A3,
    output logic [31:0]   WD3,
    input  logic [4:0]    A1,
    input  logic [4:0]    A2,
    output logic          hit1,
    output logic          hit2,
    output logic [31:0]   byp1,
    output logic [31:0]   byp2,
    output logic [CW-1:0] pending
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]    q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] head, tail;
    logic          push;

    assign in_ready = pending != CW'(DEPTH);
    // Writes to x0 complete the handshake but are dropped here.
    assign push = in_valid && in_ready && in_addr != 5'd0;
    assign RegWrite = pending != '0 && !wb_hold;
    assign A3 = q_addr[head];
    assign WD3 = q_data[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            pending <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
        end else begin
            if (push) begin
                q_addr[tail] <= in_addr;
                q_data[tail] <= in_data;
                tail <= tail + 1'b1;
            end
            if (RegWrite)
                head <= head + 1'b1;
            pending <= pending + CW'(push) - CW'(RegWrite);
        end
    end

`ifdef WBQ_BYPASS_EN
    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        logic [AW-1:0] idx;
        idx = '0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        byp1 = '0;
        byp2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (CW'(i) < pending && A1 != 5'd0 && q_addr[idx] == A1) begin
                hit1 = 1'b1;
                byp1 = q_data[idx];
            end
            if (CW'(i) < pending && A2 != 5'd0 && q_addr[idx] == A2) begin
                hit2 = 1'b1;
                byp2 = q_data[idx];
            end
        end
    end
`else
    logic unused_a;
    assign unused_a = ^{A1, A2};
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
    assign byp1 = '0;
    assign byp2 = '0;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: scoreboard bench; stimulus queues expected retirements, a monitor checks them.
module tb_wb_write_queue;
    logic        clk = 0, rst_n = 0, in_valid = 0, in_ready, wb_hold = 0;
    logic [4:0]  in_addr = 0, A1 = 0, A2 = 0, A3;
    logic [31:0] in_data = 0, WD3, byp1, byp2;
    logic        RegWrite, hit1, hit2;
    logic [2:0]  pending;
    int vectors = 0, miscompares = 0;
    logic [36:0] exp_q[$];
    logic [36:0] e;

    wb_write_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .wb_hold(wb_hold),
        .RegWrite(RegWrite), .A3(A3), .WD3(WD3), .A1(A1), .A2(A2),
        .hit1(hit1), .hit2(hit2), .byp1(byp1), .byp2(byp2), .pending(pending)
    );

    always #5 clk = ~clk;

    // Monitor: every retirement must match the oldest expected write.
    always @(negedge clk) begin
        if (RegWrite) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL retire: unexpected RegWrite A3=%0d WD3=%h, none required", A3, WD3);
            end else begin
                e = exp_q.pop_front();
                if ({A3, WD3} !== e) begin
                    miscompares++;
                    $display("FAIL retire: got A3=%0d WD3=%h, required A3=%0d WD3=%h", A3, WD3, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        int k;
        in_valid = 1;
        in_addr = a;
        in_data = d;
        k = 0;
        while (!in_ready && k < 50) begin
            cyc(1);
            k++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: in_ready=0 after 50 cycles, required 1");
        end else if (a != 0) begin
            exp_q.push_back({a, d});
        end
        cyc(1);
        in_valid = 0;
    endtask

    task automatic check_bypass(input logic h1, input logic [31:0] b1, input logic h2, input logic [31:0] b2);
`ifdef WBQ_BYPASS_EN
        check("hit1", 32'(hit1), 32'(h1));
        check("byp1", byp1, b1);
        check("hit2", 32'(hit2), 32'(h2));
        check("byp2", byp2, b2);
`else
        check("hit1_off", 32'(hit1), 32'd0);
        check("byp1_off", byp1, 32'd0);
        check("hit2_off", 32'(hit2), 32'd0);
        check("byp2_off", byp2, 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        check("rst_pending", 32'(pending), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_regwrite", 32'(RegWrite), 0);
        check("rst_a3", 32'(A3), 0);
        check("rst_wd3", WD3, 0);
        check_bypass(0, 0, 0, 0);
        rst_n = 1;
        cyc(1);

        // Single write: visible the cycle after acceptance.
        push(5, 32'hDEADBEEF);
        check("lat_regwrite", 32'(RegWrite), 1);
        check("lat_a3", 32'(A3), 5);
        check("lat_wd3", WD3, 32'hDEADBEEF);
        cyc(1);
        check("lat_pending", 32'(pending), 0);
        check("lat_regwrite_off", 32'(RegWrite), 0);

        // Fill under hold; fifth request must stall until retirement frees a slot.
        wb_hold = 1;
        push(1, 32'h100);
        push(2, 32'h200);
        push(3, 32'h300);
        push(4, 32'h400);
        check("full_pending", 32'(pending), 4);
        check("full_in_ready", 32'(in_ready), 0);
        in_valid = 1;
        in_addr = 6;
        in_data = 32'h600;
        cyc(2);
        check("stall_in_ready", 32'(in_ready), 0);
        check("stall_pending", 32'(pending), 4);
        wb_hold = 0;
        push(6, 32'h600);
        cyc(6);
        check("drain_pending", 32'(pending), 0);

        // x0 write completes the handshake without enqueueing.
        push(0, 32'h1234);
        check("x0_pending", 32'(pending), 0);
        check("x0_regwrite", 32'(RegWrite), 0);
        cyc(2);

        // Bypass reports the youngest of two queued writes to r7.
        wb_hold = 1;
        push(7, 32'h11);
        push(7, 32'h22);
        A1 = 7;
        A2 = 0;
        #1;
        check_bypass(1, 32'h22, 0, 0);
        A2 = 3;
        #1;
        check_bypass(1, 32'h22, 0, 0);
        A1 = 0;
        A2 = 0;
        wb_hold = 0;
        cyc(4);

        // Sustained push and retire: occupancy holds at one and pointers wrap.
        for (int i = 0; i < 20; i++) begin
            in_valid = 1;
            in_addr = 5'((i % 31) + 1);
            in_data = 32'(i);
            exp_q.push_back({in_addr, in_data});
            cyc(1);
            check("stream_pending", 32'(pending), 1);
        end
        in_valid = 0;
        cyc(3);
        check("stream_drained", 32'(pending), 0);

        // Reset mid-operation discards queued writes.
        wb_hold = 1;
        push(9, 32'h9);
        push(10, 32'hA);
        push(11, 32'hB);
        check("pre_rst_pending", 32'(pending), 3);
        #3;
        rst_n = 0;
        exp_q.delete();
        #1;
        check("mid_rst_pending", 32'(pending), 0);
        check("mid_rst_regwrite", 32'(RegWrite), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_a3", 32'(A3), 0);
        check("mid_rst_wd3", WD3, 0);
        wb_hold = 0;
        cyc(2);
        rst_n = 1;
        cyc(4);
        check("post_rst_regwrite", 32'(RegWrite), 0);
        check("post_rst_pending", 32'(pending), 0);
        push(12, 32'hC0FFEE);
        cyc(3);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
